// File: rtl/servo_cmd_scheduler.sv
`timescale 1ns/1ps
// servo_cmd_scheduler
//   Turns raw joystick X/Y samples into per-channel servo pulse-width commands
//   (in microseconds). A two-stage pipeline clamps and scales each axis. Each
//   channel then slews its command toward its target at a limited rate. A home
//   sequence drives a latched set of channels back to centre.
//
// Ports
//   CLK, RST_N     system clock, asynchronous active-low reset
//   x_raw, y_raw   joystick axis samples, valid when sample_valid is high
//   sample_valid   one-cycle strobe qualifying x_raw/y_raw
//   ch_en          per-channel joystick-follow enable
//   home_btn       level input; a rising edge requests the home sequence
//   cmd            packed commands, channel i at [i*CMD_W +: CMD_W]
//   at_target      per channel: command has reached its target
//   busy           home sequence in progress
module servo_cmd_scheduler #(
  parameter int unsigned        NUM_CH    = 4,
  parameter int unsigned        RAW_W     = 10,
  parameter int unsigned        CMD_W     = 16,
  parameter logic [NUM_CH-1:0]  AXIS_MAP  = 4'b1010,
  parameter int unsigned        RAW_MIN   = 228,
  parameter int unsigned        RAW_MAX   = 830,
  parameter int unsigned        PW_MIN    = 650,
  parameter int unsigned        PW_MAX    = 2600,
  parameter int unsigned        PW_CENTER = 1500,
  parameter int unsigned        SLEW_DIV  = 50000,
  parameter int unsigned        SLEW_STEP = 20
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [RAW_W-1:0]         x_raw,
  input  logic [RAW_W-1:0]         y_raw,
  input  logic                     sample_valid,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     home_btn,
  output logic [NUM_CH*CMD_W-1:0]  cmd,
  output logic [NUM_CH-1:0]        at_target,
  output logic                     busy
);

  // Q8 gain from raw offset to microseconds, rounded down.
  localparam int unsigned SCALE  = ((PW_MAX - PW_MIN) << 8) / (RAW_MAX - RAW_MIN);
  localparam int unsigned PROD_W = RAW_W + CMD_W + 8;
  localparam int unsigned CNT_W  = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;

  localparam logic [RAW_W-1:0]  RAW_MIN_V   = RAW_W'(RAW_MIN);
  localparam logic [RAW_W-1:0]  RAW_MAX_V   = RAW_W'(RAW_MAX);
  localparam logic [CMD_W-1:0]  PW_MIN_V    = CMD_W'(PW_MIN);
  localparam logic [CMD_W-1:0]  PW_MAX_V    = CMD_W'(PW_MAX);
  localparam logic [CMD_W-1:0]  PW_CENTER_V = CMD_W'(PW_CENTER);
  localparam logic [CMD_W-1:0]  STEP_V      = CMD_W'(SLEW_STEP);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(SLEW_DIV - 1);
  localparam logic [PROD_W-1:0] SCALE_V     = PROD_W'(SCALE);

  typedef enum logic {IDLE, HOMING} state_t;

  // ---------------- Stage 1: clamp and offset per axis (0 = X, 1 = Y)
  logic [RAW_W-1:0] s1_d_d [2];
  logic [RAW_W-1:0] s1_d_q [2];
  logic [1:0]       s1_lo_d, s1_hi_d, s1_lo_q, s1_hi_q;
  logic             s1_valid;

  always_comb begin
    for (int a = 0; a < 2; a++) begin
      logic [RAW_W-1:0] raw;
      raw = (a == 0) ? x_raw : y_raw;
      s1_lo_d[a] = (raw <= RAW_MIN_V);
      s1_hi_d[a] = (raw >= RAW_MAX_V);
      if (s1_lo_d[a])      s1_d_d[a] = '0;
      else if (s1_hi_d[a]) s1_d_d[a] = RAW_MAX_V - RAW_MIN_V;
      else                 s1_d_d[a] = raw - RAW_MIN_V;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) s1_valid <= 1'b0;
    else        s1_valid <= sample_valid;
  end

  // NOTE: the datapath registers carry no reset; only the valid flag has to be
  // defined after reset, and the data is never consumed without it.
  always_ff @(posedge CLK) begin
    if (sample_valid) begin
      s1_d_q  <= s1_d_d;
      s1_lo_q <= s1_lo_d;
      s1_hi_q <= s1_hi_d;
    end
  end

  // ---------------- Stage 2: scale to microseconds, endpoints forced exact
  logic [PROD_W-1:0] prod  [2];
  logic [CMD_W-1:0]  pw_ax [2];

  always_comb begin
    for (int a = 0; a < 2; a++) begin
      prod[a] = PROD_W'(s1_d_q[a]) * SCALE_V;
      if (s1_lo_q[a])      pw_ax[a] = PW_MIN_V;
      else if (s1_hi_q[a]) pw_ax[a] = PW_MAX_V;
      else                 pw_ax[a] = PW_MIN_V + CMD_W'(prod[a] >> 8);
    end
  end

  // ---------------- Targets, slew and home control
  state_t            state_q;
  logic              btn_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NUM_CH-1:0] home_set_q;
  logic [CMD_W-1:0]  target_q [NUM_CH];
  logic [CMD_W-1:0]  cmd_q    [NUM_CH];
  logic [CMD_W-1:0]  target_d [NUM_CH];
  logic [CMD_W-1:0]  cmd_d    [NUM_CH];
  logic [NUM_CH-1:0] at_d;
  logic [NUM_CH-1:0] new_set, hold_mask;
  logic              start_home, tick, home_done;

  assign tick       = (cnt_q == CNT_LAST);
  assign start_home = (state_q == IDLE) && home_btn && !btn_q;
  // An empty enable set means "home everything".
  assign new_set    = (ch_en == '0) ? '1 : ch_en;
  // Channels whose stage-2 results are discarded this cycle.
  assign hold_mask  = start_home ? new_set :
                      ((state_q == HOMING) ? home_set_q : '0);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      logic [CMD_W-1:0] diff;
      diff        = '0;
      target_d[i] = target_q[i];
      cmd_d[i]    = cmd_q[i];

      if (start_home && new_set[i])
        target_d[i] = PW_CENTER_V;
      else if (s1_valid && ch_en[i] && !hold_mask[i])
        target_d[i] = pw_ax[AXIS_MAP[i]];

      // Slew toward the target held before this edge, never past it.
      if (SLEW_STEP == 0) begin
        cmd_d[i] = target_q[i];
      end else if (tick) begin
        if (target_q[i] > cmd_q[i]) begin
          diff     = target_q[i] - cmd_q[i];
          cmd_d[i] = (diff > STEP_V) ? cmd_q[i] + STEP_V : target_q[i];
        end else if (target_q[i] < cmd_q[i]) begin
          diff     = cmd_q[i] - target_q[i];
          cmd_d[i] = (diff > STEP_V) ? cmd_q[i] - STEP_V : target_q[i];
        end
      end

      at_d[i] = (cmd_d[i] == target_d[i]);
    end
  end

  // The home sequence ends on the same edge its last channel arrives.
  assign home_done = &(at_d | ~home_set_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      btn_q      <= 1'b0;
      cnt_q      <= '0;
      home_set_q <= '0;
      busy       <= 1'b0;
      at_target  <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= PW_CENTER_V;
        cmd_q[i]    <= PW_CENTER_V;
      end
    end else begin
      btn_q     <= home_btn;
      cnt_q     <= tick ? '0 : cnt_q + CNT_W'(1);
      target_q  <= target_d;
      cmd_q     <= cmd_d;
      at_target <= at_d;
      case (state_q)
        IDLE: if (start_home) begin
          state_q    <= HOMING;
          home_set_q <= new_set;
          busy       <= 1'b1;
        end
        HOMING: if (home_done) begin
          state_q    <= IDLE;
          home_set_q <= '0;
          busy       <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign cmd[g*CMD_W +: CMD_W] = cmd_q[g];
  end

endmodule

// File: tb/tb_servo_cmd_scheduler.sv
`timescale 1ns/1ps
// Bench for servo_cmd_scheduler. Two instances share all inputs: u_fast has
// no slew limiting (SLEW_STEP = 0), u_slew steps 50 us every 4 clocks. A
// behavioural model tracks both and is compared every clock; directed
// literal checks pin the model's arithmetic and timing.
module tb_servo_cmd_scheduler;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [9:0]  x_raw, y_raw;
  logic        sample_valid, home_btn;
  logic [3:0]  ch_en;
  logic [63:0] cmd_f, cmd_s;
  logic [3:0]  at_f, at_s;
  logic        busy_f, busy_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  servo_cmd_scheduler #(.SLEW_DIV(4), .SLEW_STEP(0)) u_fast (
    .CLK(CLK), .RST_N(RST_N), .x_raw(x_raw), .y_raw(y_raw),
    .sample_valid(sample_valid), .ch_en(ch_en), .home_btn(home_btn),
    .cmd(cmd_f), .at_target(at_f), .busy(busy_f));

  servo_cmd_scheduler #(.SLEW_DIV(4), .SLEW_STEP(50)) u_slew (
    .CLK(CLK), .RST_N(RST_N), .x_raw(x_raw), .y_raw(y_raw),
    .sample_valid(sample_valid), .ch_en(ch_en), .home_btn(home_btn),
    .cmd(cmd_s), .at_target(at_s), .busy(busy_s));

  // ---------------- Behavioural model (index 0 = u_fast, 1 = u_slew)
  localparam int SCALE = ((2600 - 650) * 256) / (830 - 228);
  logic [3:0] axis_map = 4'b1010;
  int         m_tgt [2][4];
  int         m_cmd [2][4];
  int         m_cnt [2];
  logic [3:0] m_at  [2];
  logic [3:0] m_set [2];
  logic       m_busy[2];
  logic       p_valid, btn_prev;
  int         p_x, p_y;

  function automatic int pw_of(input int raw);
    if (raw <= 228) return 650;
    if (raw >= 830) return 2600;
    return 650 + ((raw - 228) * SCALE) / 256;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_tgt[k][i] = 1500;
        m_cmd[k][i] = 1500;
      end
      m_cnt[k]  = 0;
      m_at[k]   = 4'hF;
      m_set[k]  = 4'h0;
      m_busy[k] = 1'b0;
    end
    p_valid = 1'b0; p_x = 0; p_y = 0; btn_prev = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at that edge.
  task automatic model_step();
    int old_tgt [4];
    int pwx, pwy, d, step;
    logic rise, start, tick, blk;
    logic [3:0] nset;
    if (!RST_N) begin
      model_reset();
      return;
    end
    rise = home_btn && !btn_prev;
    nset = (ch_en == 4'h0) ? 4'hF : ch_en;
    pwx  = pw_of(p_x);
    pwy  = pw_of(p_y);
    for (int k = 0; k < 2; k++) begin
      step  = (k == 0) ? 0 : 50;
      start = !m_busy[k] && rise;
      for (int i = 0; i < 4; i++) begin
        old_tgt[i] = m_tgt[k][i];
        blk = start ? nset[i] : (m_busy[k] && m_set[k][i]);
        if (start && nset[i])                     m_tgt[k][i] = 1500;
        else if (p_valid && ch_en[i] && !blk)     m_tgt[k][i] = axis_map[i] ? pwy : pwx;
      end
      tick     = (m_cnt[k] == 3);
      m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
      for (int i = 0; i < 4; i++) begin
        if (step == 0) m_cmd[k][i] = old_tgt[i];
        else if (tick) begin
          d = old_tgt[i] - m_cmd[k][i];
          if (d > step)  d = step;
          if (d < -step) d = -step;
          m_cmd[k][i] += d;
        end
        m_at[k][i] = (m_cmd[k][i] == m_tgt[k][i]);
      end
      if (start) begin
        m_busy[k] = 1'b1;
        m_set[k]  = nset;
      end else if (m_busy[k] && ((m_at[k] | ~m_set[k]) == 4'hF)) begin
        m_busy[k] = 1'b0;
        m_set[k]  = 4'h0;
      end
    end
    p_valid = sample_valid; p_x = int'(x_raw); p_y = int'(y_raw); btn_prev = home_btn;
  endtask

  // ---------------- Checking helpers
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int get_cmd(input int k, input int i);
    return (k == 0) ? int'(cmd_f[i*16 +: 16]) : int'(cmd_s[i*16 +: 16]);
  endfunction

  function automatic int get_at(input int k);
    return (k == 0) ? int'(at_f) : int'(at_s);
  endfunction

  function automatic int get_busy(input int k);
    return (k == 0) ? int'(busy_f) : int'(busy_s);
  endfunction

  // Compare every output of both instances against the model each clock.
  always @(negedge CLK) begin
    if (RST_N) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++)
          check($sformatf("model dut%0d cmd%0d", k, i), get_cmd(k, i), m_cmd[k][i]);
        check($sformatf("model dut%0d at_target", k), get_at(k), int'(m_at[k]));
        check($sformatf("model dut%0d busy", k), get_busy(k), int'(m_busy[k]));
      end
    end
  end

  // ---------------- Stimulus
  task automatic cyc();
    @(posedge CLK);
    #1;
    model_step();
  endtask

  // One sample strobe, then wait until u_fast's commands reflect it.
  task automatic apply(input int x, input int y);
    x_raw = 10'(x); y_raw = 10'(y); sample_valid = 1'b1;
    cyc();
    sample_valid = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic check_fast(input string tag, input int e0, input int e1);
    check({tag, " fast cmd0"}, get_cmd(0, 0), e0);
    check({tag, " fast cmd1"}, get_cmd(0, 1), e1);
    check({tag, " fast cmd2"}, get_cmd(0, 2), e0);
    check({tag, " fast cmd3"}, get_cmd(0, 3), e1);
  endtask

  initial begin
    int exp_steps [3];
    int found, prev, last, cur, steps;
    exp_steps = '{1550, 1600, 1624};

    RST_N = 1'b0; x_raw = '0; y_raw = '0; sample_valid = 1'b0;
    ch_en = 4'h0; home_btn = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b1;

    // Reset state after idle clocks.
    repeat (10) cyc();
    for (int i = 0; i < 4; i++) check("reset fast cmd", get_cmd(0, i), 1500);
    check("reset slew cmd0", get_cmd(1, 0), 1500);
    check("reset at_target", int'(at_s), 15);
    check("reset busy", int'(busy_s), 0);

    // Single channel, mid-range sample: 529 -> 1624.
    ch_en = 4'b0001; x_raw = 10'd529; y_raw = 10'd0; sample_valid = 1'b1;
    cyc();
    sample_valid = 1'b0;
    cyc();
    check("latency fast cmd0 not yet", get_cmd(0, 0), 1500);
    check("slew at0 low on target change", int'(at_s[0]), 0);
    found = 0; prev = 1500; last = 0;
    for (int c = 1; c <= 20 && found < 3; c++) begin
      cyc();
      if (c == 1) begin
        check("t+3 fast cmd0", get_cmd(0, 0), 1624);
        for (int i = 1; i < 4; i++) check("t+3 fast other cmd", get_cmd(0, i), 1500);
      end
      cur = get_cmd(1, 0);
      if (cur != prev) begin
        check("slew step value", cur, exp_steps[found]);
        if (found > 0) check("slew step spacing", c - last, 4);
        last = c; prev = cur; found++;
      end
      check("slew at0 follows arrival", int'(at_s[0]), (found == 3) ? 1 : 0);
    end
    check("slew steps seen", found, 3);

    // All channels, clamping and endpoints.
    ch_en = 4'b1111;
    apply(1000, 100);  check_fast("over/under", 2600, 650);
    apply(228, 830);   check_fast("exact ends", 650, 2600);
    apply(830, 228);   check_fast("exact ends swap", 2600, 650);
    apply(700, 400);   check_fast("mid", 2178, 1206);
    apply(229, 829);   check_fast("inside ends", 653, 2596);

    // Home sequence on channel 0 while samples keep requesting 2600.
    ch_en = 4'b0001; x_raw = 10'd830; y_raw = 10'd500; sample_valid = 1'b1;
    for (int c = 0; c < 400 && get_cmd(1, 0) != 2600; c++) cyc();
    check("slew reached 2600", get_cmd(1, 0), 2600);
    home_btn = 1'b1;
    cyc();
    check("busy rises", int'(busy_s), 1);
    prev = get_cmd(1, 0); steps = 0;
    for (int c = 0; c < 200; c++) begin
      if (c == 8)  home_btn = 1'b0;
      if (c == 12) home_btn = 1'b1;
      cyc();
      cur = get_cmd(1, 0);
      if (cur != prev) begin
        check("home step size", prev - cur, 50);
        steps++;
        prev = cur;
      end
      check("busy vs at_target0", int'(busy_s), at_s[0] ? 0 : 1);
      if (!busy_s) break;
    end
    check("home end cmd0", get_cmd(1, 0), 1500);
    check("home step count", steps, 22);
    check("busy falls", int'(busy_s), 0);
    home_btn = 1'b0;

    // Reset while slewing back up.
    for (int c = 0; c < 200 && get_cmd(1, 0) != 2100; c++) cyc();
    check("slew reached 2100", get_cmd(1, 0), 2100);
    sample_valid = 1'b0;
    #1 RST_N = 1'b0;
    model_reset();
    #1;
    check("async reset slew cmd0", get_cmd(1, 0), 1500);
    check("async reset fast cmd0", get_cmd(0, 0), 1500);
    check("async reset at_target", int'(at_s), 15);
    check("async reset busy", int'(busy_s), 0);
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
    repeat (20) cyc();
    check("held after reset", get_cmd(1, 0), 1500);
    x_raw = 10'd529; sample_valid = 1'b1;
    cyc();
    sample_valid = 1'b0;
    repeat (30) cyc();
    check("resume after sample", get_cmd(1, 0), 1624);
    check("resume at_target0", int'(at_s[0]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/servo_cmd_scheduler.md
Name: servo_cmd_scheduler

Overview:
- Parametrised successor to the joystick-to-servo command path.
- Maps raw joystick X/Y samples to servo pulse-width commands in µs for NUM_CH channels.
- Adds saturating fixed-point scaling, per-channel slew limiting, and a sequenced home-to-centre mode.
- Sits between the joystick reader and the per-channel servo PWM generators; drives their control inputs.

Parameters:
- NUM_CH, 4, number of servo channels.
- RAW_W, 10, width of raw joystick axis samples.
- CMD_W, 16, width of each pulse-width command (µs).
- AXIS_MAP, 4'b1010, bit i selects the source for channel i: 0 = X, 1 = Y.
- RAW_MIN, 228, raw value mapped to PW_MIN.
- RAW_MAX, 830, raw value mapped to PW_MAX.
- PW_MIN, 650, minimum command (µs).
- PW_MAX, 2600, maximum command (µs).
- PW_CENTER, 1500, reset and home command (µs).
- SLEW_DIV, 50000, clocks per slew tick; minimum 1.
- SLEW_STEP, 20, maximum command change per tick (µs); 0 disables limiting.

Ports:
- CLK, in, 1, system clock.
- RST_N, in, 1, asynchronous active-low reset.
- x_raw, in, RAW_W, joystick X sample.
- y_raw, in, RAW_W, joystick Y sample.
- sample_valid, in, 1, one-cycle strobe; x_raw and y_raw are valid this cycle.
- ch_en, in, NUM_CH, per-channel joystick-follow enable (switch inputs).
- home_btn, in, 1, level input; its rising edge requests home.
- cmd, out, NUM_CH*CMD_W, packed commands; channel i occupies bits [i*CMD_W +: CMD_W].
- at_target, out, NUM_CH, per channel: cmd equals the internal target.
- busy, out, 1, home sequence in progress.

Behaviour:
- Reset (async assert on RST_N low, sync release):
  - cmd[i] = PW_CENTER; target[i] = PW_CENTER.
  - at_target = all ones; busy = 0.
  - Slew counter = 0; FSM = IDLE.
  - home_btn edge-detect register = 0, so a button already held at reset release does not trigger home.
- Scaling pipeline (2 stages):
  - Stage 1: per axis, clamp raw to [RAW_MIN, RAW_MAX]; register the offset d = raw − RAW_MIN and the flags lo = (raw ≤ RAW_MIN) and hi = (raw ≥ RAW_MAX).
  - Stage 2: pw = PW_MIN + ((d * SCALE) >> 8).
    - SCALE = floor(((PW_MAX − PW_MIN) << 8) / (RAW_MAX − RAW_MIN)), a localparam.
    - Force pw = PW_MIN if lo; force pw = PW_MAX if hi.
    - Product width ≥ RAW_W + CMD_W + 8; no truncation before the shift.
  - sample_valid at cycle t → targets update at the t+2 edge for every channel with ch_en[i] = 1 that is not in the home set.
  - A stage-2 result for a channel in the home set is discarded.
- Slew:
  - Free-running counter 0..SLEW_DIV−1; a tick fires when it wraps.
  - On a tick, for each channel with cmd ≠ target, cmd moves toward target by min(SLEW_STEP, |target − cmd|). No overshoot.
  - SLEW_STEP = 0: cmd <= target every cycle, i.e. the cycle after target changes.
  - at_target[i] is registered and equals (cmd[i] == target[i]) after the update.
- Home FSM (IDLE, HOMING):
  - IDLE → HOMING on a home_btn rising edge:
    - Latch home_set = ch_en; if ch_en is all zero, home_set = all ones.
    - Set target[i] = PW_CENTER for every i in home_set; busy = 1 the next cycle.
  - HOMING → IDLE when at_target[i] = 1 for all i in home_set; busy = 0 that cycle; home_set cleared.
  - In HOMING: further home edges are ignored; ch_en changes do not alter home_set; channels outside home_set keep following samples.
- Simultaneous events:
  - Home edge and a stage-2 write in the same cycle: home wins for channels in home_set.
  - Disabled channels hold their target and keep slewing to it.
- Reset mid-slew or mid-home: everything returns to its reset values immediately.

Test Plan:
- Reset, then 10 idle cycles → every cmd = 1500, at_target = 4'b1111, busy = 0.
- SLEW_STEP = 0, ch_en = 4'b0001, x_raw = 529 with one sample_valid strobe:
  - cmd0 = 1624 at t+3.
  - cmd1..cmd3 stay 1500.
- SLEW_STEP = 0, ch_en = 4'b1111:
  - x_raw = 1000, y_raw = 100 → cmd0 = cmd2 = 2600, cmd1 = cmd3 = 650.
  - x_raw = 830 → 2600; x_raw = 228 → 650.
- SLEW_DIV = 4, SLEW_STEP = 50, target0 → 1624:
  - cmd0 steps 1550, 1600, 1624 on successive ticks, 4 clocks apart.
  - at_target[0] low until 1624.
- SLEW_DIV = 4, SLEW_STEP = 50, cmd0 = 2600, ch_en = 4'b0001, pulse home_btn while sample_valid keeps driving x_raw = 830:
  - busy rises.
  - cmd0 descends in steps of 50 to 1500.
  - busy falls the cycle at_target[0] = 1.
  - The second home edge mid-sequence has no effect.
- Assert RST_N low while slewing (cmd0 = 2100) → cmd0 = 1500 the same cycle; slewing resumes only after new samples.
